// File: rtl/m_instruction_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one 8-bit word per instruction
// over a ready handshake and presents it to the decoder until it advances.
module m_instruction_fetch_unit #(
    parameter int                  PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [7:0]          HALT_WORD = 8'h00
) (
    input  logic                w_clock,
    input  logic                w_reset,
    output logic                w_imem_req,
    output logic [PC_WIDTH-1:0] w_imem_addr,
    input  logic [7:0]          w_imem_data,
    input  logic                w_imem_ready,
    output logic [7:0]          w_bus_wordout,
    output logic                w_instr_valid,
    input  logic                w_advance,
    input  logic                w_jump_flag,
    input  logic [PC_WIDTH-1:0] w_jump_target,
    output logic [PC_WIDTH-1:0] w_pc,
    output logic [PC_WIDTH-1:0] w_link_pc,
    output logic                w_halted,
    output logic [15:0]         w_retire_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [15:0]         retire_q, retire_d;
    logic [PC_WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + PC_WIDTH'(1);

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 8'h00;
            retire_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        retire_d = retire_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (w_imem_ready) begin
                    // The halt word is left out of the instruction register so the
                    // decoder never sees it.
                    if (w_imem_data == HALT_WORD) begin
                        state_d = S_HALT;
                    end else begin
                        ir_d    = w_imem_data;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_advance) begin
                    pc_d    = w_jump_flag ? w_jump_target : pc_inc;
                    state_d = S_FETCH;
                    if (retire_q != 16'hFFFF) begin
                        retire_d = retire_q + 16'd1;
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign w_imem_req     = (state_q == S_FETCH);
    assign w_imem_addr    = pc_q;
    assign w_instr_valid  = (state_q == S_ISSUE);
    assign w_bus_wordout  = ir_q;
    assign w_halted       = (state_q == S_HALT);
    assign w_pc           = pc_q;
    assign w_link_pc      = pc_inc;
    assign w_retire_count = retire_q;

endmodule

// File: tb/tb_m_instruction_fetch_unit.sv
// Directed bench for the fetch stage; expected values are hand-derived constants
// plus a running expected PC and retire count.
module tb_m_instruction_fetch_unit;

    logic       w_clock = 1'b0;
    logic       w_reset;
    logic       w_imem_req;
    logic [7:0] w_imem_addr;
    logic [7:0] w_imem_data;
    logic       w_imem_ready;
    logic [7:0] w_bus_wordout;
    logic       w_instr_valid;
    logic       w_advance;
    logic       w_jump_flag;
    logic [7:0] w_jump_target;
    logic [7:0] w_pc;
    logic [7:0] w_link_pc;
    logic       w_halted;
    logic [15:0] w_retire_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_pc;
    logic [15:0] exp_ret;

    m_instruction_fetch_unit #(
        .PC_WIDTH (8),
        .RESET_PC (8'h00),
        .HALT_WORD(8'h00)
    ) dut (
        .w_clock       (w_clock),
        .w_reset       (w_reset),
        .w_imem_req    (w_imem_req),
        .w_imem_addr   (w_imem_addr),
        .w_imem_data   (w_imem_data),
        .w_imem_ready  (w_imem_ready),
        .w_bus_wordout (w_bus_wordout),
        .w_instr_valid (w_instr_valid),
        .w_advance     (w_advance),
        .w_jump_flag   (w_jump_flag),
        .w_jump_target (w_jump_target),
        .w_pc          (w_pc),
        .w_link_pc     (w_link_pc),
        .w_halted      (w_halted),
        .w_retire_count(w_retire_count)
    );

    always #5 w_clock = ~w_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge w_clock);
        #1;
    endtask

    // Starts in FETCH: returns a word with ready=1 and checks it is presented next cycle.
    task automatic fetch_word(input string tag, input logic [7:0] word);
        check({tag, " req"}, {31'd0, w_imem_req}, 32'd1);
        check({tag, " addr"}, {24'd0, w_imem_addr}, {24'd0, exp_pc});
        check({tag, " valid before ready"}, {31'd0, w_instr_valid}, 32'd0);
        w_imem_ready = 1'b1;
        w_imem_data  = word;
        step();
        w_imem_ready = 1'b0;
        w_imem_data  = 8'hEE;
        check({tag, " valid"}, {31'd0, w_instr_valid}, 32'd1);
        check({tag, " word"}, {24'd0, w_bus_wordout}, {24'd0, word});
        check({tag, " req in issue"}, {31'd0, w_imem_req}, 32'd0);
    endtask

    // Starts in ISSUE: advances and checks the next fetch address.
    task automatic advance(input string tag, input logic jf, input logic [7:0] tgt,
                           input logic [7:0] next_addr);
        w_advance     = 1'b1;
        w_jump_flag   = jf;
        w_jump_target = tgt;
        step();
        w_advance     = 1'b0;
        w_jump_flag   = 1'b0;
        w_jump_target = 8'h00;
        exp_pc  = next_addr;
        exp_ret = exp_ret + 16'd1;
        check({tag, " next addr"}, {24'd0, w_imem_addr}, {24'd0, next_addr});
        check({tag, " next req"}, {31'd0, w_imem_req}, 32'd1);
        check({tag, " retire"}, {16'd0, w_retire_count}, {16'd0, exp_ret});
    endtask

    initial begin
        w_reset = 1'b1; w_imem_data = 8'h00; w_imem_ready = 1'b0;
        w_advance = 1'b0; w_jump_flag = 1'b0; w_jump_target = 8'h00;
        exp_pc = 8'h00; exp_ret = 16'd0;
        step(); step();

        check("rst req", {31'd0, w_imem_req}, 32'd0);
        check("rst valid", {31'd0, w_instr_valid}, 32'd0);
        check("rst halted", {31'd0, w_halted}, 32'd0);
        check("rst word", {24'd0, w_bus_wordout}, 32'h00);
        check("rst pc", {24'd0, w_pc}, 32'h00);
        check("rst link", {24'd0, w_link_pc}, 32'h01);
        check("rst retire", {16'd0, w_retire_count}, 32'd0);

        // Sequential run 0..2; req low in the deassertion cycle
        w_reset = 1'b0;
        check("idle req", {31'd0, w_imem_req}, 32'd0);
        step();
        fetch_word("seq0", 8'h1F);
        check("seq0 pc", {24'd0, w_pc}, 32'h00);
        w_imem_ready = 1'b1; w_imem_data = 8'h99;
        step();
        w_imem_ready = 1'b0;
        check("ready in issue ignored", {24'd0, w_bus_wordout}, 32'h1F);
        check("still valid", {31'd0, w_instr_valid}, 32'd1);
        advance("seq0", 1'b0, 8'h00, 8'h01);
        fetch_word("seq1", 8'h23);
        check("seq1 pc", {24'd0, w_pc}, 32'h01);
        advance("seq1", 1'b0, 8'h00, 8'h02);
        fetch_word("seq2", 8'h45);
        check("seq2 pc", {24'd0, w_pc}, 32'h02);
        advance("seq2", 1'b0, 8'h00, 8'h03);
        check("retire 3", {16'd0, w_retire_count}, 32'd3);

        fetch_word("seq3", 8'h11);
        advance("seq3", 1'b0, 8'h00, 8'h04);

        // Wait states at address 4; advance during FETCH must be ignored
        for (int i = 0; i < 3; i++) begin
            w_advance = 1'b1;
            step();
            check("wait req", {31'd0, w_imem_req}, 32'd1);
            check("wait addr", {24'd0, w_imem_addr}, 32'h04);
            check("wait valid", {31'd0, w_instr_valid}, 32'd0);
        end
        w_advance = 1'b0;
        fetch_word("wait", 8'h22);
        advance("wait jump", 1'b1, 8'h08, 8'h08);

        // Jump and link at PC 8
        fetch_word("jal", 8'hA3);
        check("jal link", {24'd0, w_link_pc}, 32'h09);
        advance("jal", 1'b1, 8'h40, 8'h40);
        fetch_word("at40", 8'h55);
        advance("at40 back", 1'b1, 8'h08, 8'h08);
        fetch_word("pc8 again", 8'hA3);
        advance("no jump", 1'b0, 8'h77, 8'h09);

        // Wrap-around at 255
        fetch_word("pc9", 8'h31);
        advance("to ff", 1'b1, 8'hFF, 8'hFF);
        fetch_word("pcff", 8'h66);
        check("ff link", {24'd0, w_link_pc}, 32'h00);
        advance("wrap", 1'b0, 8'h00, 8'h00);

        // Self-loop refetches the same address
        fetch_word("self", 8'h77);
        advance("self", 1'b1, 8'h00, 8'h00);
        fetch_word("self2", 8'h78);
        advance("to 5", 1'b1, 8'h05, 8'h05);

        // Reset in ISSUE at PC 5 together with advance
        fetch_word("pc5", 8'h99);
        w_reset = 1'b1; w_advance = 1'b1;
        check("rst cycle valid", {31'd0, w_instr_valid}, 32'd1);
        check("rst cycle pc", {24'd0, w_pc}, 32'h05);
        step();
        w_advance = 1'b0;
        check("mid rst pc", {24'd0, w_pc}, 32'h00);
        check("mid rst retire", {16'd0, w_retire_count}, 32'd0);
        check("mid rst valid", {31'd0, w_instr_valid}, 32'd0);
        w_imem_ready = 1'b1; w_imem_data = 8'h44;
        step();
        check("held rst req", {31'd0, w_imem_req}, 32'd0);
        w_reset = 1'b0; w_imem_ready = 1'b0;
        check("release req", {31'd0, w_imem_req}, 32'd0);
        step();
        exp_pc = 8'h00; exp_ret = 16'd0;
        check("restart addr", {24'd0, w_imem_addr}, 32'h00);

        // Halt at PC 6
        fetch_word("pre halt", 8'h12);
        advance("to 6", 1'b1, 8'h06, 8'h06);
        w_imem_ready = 1'b1; w_imem_data = 8'h00;
        step();
        w_imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("halt halted", {31'd0, w_halted}, 32'd1);
            check("halt pc", {24'd0, w_pc}, 32'h06);
            check("halt valid", {31'd0, w_instr_valid}, 32'd0);
            check("halt req", {31'd0, w_imem_req}, 32'd0);
            check("halt retire", {16'd0, w_retire_count}, 32'd1);
            w_advance = 1'b1; w_imem_ready = 1'b1; w_imem_data = 8'h5A;
            step();
            w_advance = 1'b0; w_imem_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
